// File: rtl/ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder
//
// Purpose:
//   Sits directly behind the ps2_keyboard FIFO. It pops one raw PS/2 set-2
//   scan-code byte at a time and folds the E0 (extended) and F0 (break)
//   prefixes into single press/release events. It can suppress typematic
//   repeats, counts key presses and maps common keys to lowercase ASCII.
//
// Parameters:
//   CNT_W           width of press_cnt (wraps modulo 2^CNT_W)
//   SUPPRESS_REPEAT 1 = a repeated make of the held key is dropped
//                   0 = a repeated make emits an event with evt_repeat=1
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   ps2_data        FIFO head byte, valid while ps2_ready=1
//   ps2_ready       FIFO non-empty
//   ps2_overflow    FIFO overflow flag
//   ps2_nextdata_n  active-low pop strobe, one cycle per byte
//   evt_valid       one-cycle event pulse
//   evt_code        scan code of the event, prefixes stripped
//   evt_ext         event carried the E0 prefix
//   evt_release     1 = break, 0 = make
//   evt_repeat      make of an already-held key
//   evt_ascii       lowercase ASCII of evt_code, 0x00 if unmapped/extended
//   key_down        a key is currently held
//   cur_code        code of the held key (last make)
//   cur_ext         extended flag of the held key
//   press_cnt       count of non-repeat make events
//   err             sticky overflow indicator
// ---------------------------------------------------------------------------
module ps2_key_decoder #(
   parameter int CNT_W           = 8,
   parameter bit SUPPRESS_REPEAT = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       ps2_data,
   input  logic             ps2_ready,
   input  logic             ps2_overflow,
   output logic             ps2_nextdata_n,
   output logic             evt_valid,
   output logic [7:0]       evt_code,
   output logic             evt_ext,
   output logic             evt_release,
   output logic             evt_repeat,
   output logic [7:0]       evt_ascii,
   output logic             key_down,
   output logic [7:0]       cur_code,
   output logic             cur_ext,
   output logic [CNT_W-1:0] press_cnt,
   output logic             err
);

   localparam logic [7:0] CODE_EXT = 8'hE0;
   localparam logic [7:0] CODE_BRK = 8'hF0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      POP  = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t     state_reg;
   logic [7:0] byte_reg;
   logic       ext_pend_reg;
   logic       brk_pend_reg;

   // Decode helpers evaluated against the byte captured in IDLE.
   logic       same_key;
   logic       is_repeat;
   logic [7:0] ascii_val;

   function automatic logic [7:0] set2_to_ascii(input logic [7:0] code);
      logic [7:0] a;
      a = 8'h00;
      case (code)
         8'h1C: a = "a";  8'h32: a = "b";  8'h21: a = "c";  8'h23: a = "d";
         8'h24: a = "e";  8'h2B: a = "f";  8'h34: a = "g";  8'h33: a = "h";
         8'h43: a = "i";  8'h3B: a = "j";  8'h42: a = "k";  8'h4B: a = "l";
         8'h3A: a = "m";  8'h31: a = "n";  8'h44: a = "o";  8'h4D: a = "p";
         8'h15: a = "q";  8'h2D: a = "r";  8'h1B: a = "s";  8'h2C: a = "t";
         8'h3C: a = "u";  8'h2A: a = "v";  8'h1D: a = "w";  8'h22: a = "x";
         8'h35: a = "y";  8'h1A: a = "z";
         8'h45: a = "0";  8'h16: a = "1";  8'h1E: a = "2";  8'h26: a = "3";
         8'h25: a = "4";  8'h2E: a = "5";  8'h36: a = "6";  8'h3D: a = "7";
         8'h3E: a = "8";  8'h46: a = "9";
         8'h29: a = 8'h20;
         8'h5A: a = 8'h0D;
         default: a = 8'h00;
      endcase
      return a;
   endfunction

   always_comb begin
      same_key  = key_down && (cur_code == byte_reg) && (cur_ext == ext_pend_reg);
      is_repeat = same_key && !brk_pend_reg;
      ascii_val = ext_pend_reg ? 8'h00 : set2_to_ascii(byte_reg);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         byte_reg       <= 8'h00;
         ext_pend_reg   <= 1'b0;
         brk_pend_reg   <= 1'b0;
         ps2_nextdata_n <= 1'b1;
         evt_valid      <= 1'b0;
         evt_code       <= 8'h00;
         evt_ext        <= 1'b0;
         evt_release    <= 1'b0;
         evt_repeat     <= 1'b0;
         evt_ascii      <= 8'h00;
         key_down       <= 1'b0;
         cur_code       <= 8'h00;
         cur_ext        <= 1'b0;
         press_cnt      <= '0;
         err            <= 1'b0;
      end else begin
         // Overflow is tracked independently of the byte handshake.
         if (ps2_overflow)
            err <= 1'b1;

         // evt_valid is a single-cycle pulse; only the POP branch raises it.
         evt_valid <= 1'b0;

         case (state_reg)
            IDLE: begin
               ps2_nextdata_n <= 1'b1;
               if (ps2_ready) begin
                  byte_reg       <= ps2_data;
                  ps2_nextdata_n <= 1'b0;   // low during the POP cycle only
                  state_reg      <= POP;
               end
            end

            POP: begin
               ps2_nextdata_n <= 1'b1;
               state_reg      <= GAP;
               if (byte_reg == CODE_EXT) begin
                  ext_pend_reg <= 1'b1;
               end else if (byte_reg == CODE_BRK) begin
                  brk_pend_reg <= 1'b1;
               end else begin
                  ext_pend_reg <= 1'b0;
                  brk_pend_reg <= 1'b0;
                  if (brk_pend_reg) begin
                     evt_valid   <= 1'b1;
                     evt_code    <= byte_reg;
                     evt_ext     <= ext_pend_reg;
                     evt_release <= 1'b1;
                     evt_repeat  <= 1'b0;
                     evt_ascii   <= ascii_val;
                     // Releasing a key other than the held one leaves it held.
                     if (same_key)
                        key_down <= 1'b0;
                  end else if (is_repeat) begin
                     if (!SUPPRESS_REPEAT) begin
                        evt_valid   <= 1'b1;
                        evt_code    <= byte_reg;
                        evt_ext     <= ext_pend_reg;
                        evt_release <= 1'b0;
                        evt_repeat  <= 1'b1;
                        evt_ascii   <= ascii_val;
                     end
                  end else begin
                     evt_valid   <= 1'b1;
                     evt_code    <= byte_reg;
                     evt_ext     <= ext_pend_reg;
                     evt_release <= 1'b0;
                     evt_repeat  <= 1'b0;
                     evt_ascii   <= ascii_val;
                     press_cnt   <= press_cnt + 1'b1;
                     key_down    <= 1'b1;
                     cur_code    <= byte_reg;
                     cur_ext     <= ext_pend_reg;
                  end
               end
            end

            GAP: begin
               // Gives the FIFO one cycle to advance its read pointer.
               ps2_nextdata_n <= 1'b1;
               state_reg      <= IDLE;
            end

            default: begin
               ps2_nextdata_n <= 1'b1;
               state_reg      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_decoder
//
// Two decoders (repeat suppression on and off) share one modelled FIFO.
// Their handshake timing is identical, so the FIFO is popped from the
// suppressing instance's strobe. Directed steps in one initial block.
// ---------------------------------------------------------------------------
module tb_ps2_key_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] ps2_data = 8'h00;
   logic       ps2_ready = 1'b0;
   logic       ps2_overflow = 1'b0;

   // Instance s: SUPPRESS_REPEAT=1, instance r: SUPPRESS_REPEAT=0
   logic       nd_s, ev_s, ext_s, rel_s, rep_s, kd_s, cext_s, err_s;
   logic [7:0] code_s, asc_s, cc_s, pc_s;
   logic       nd_r, ev_r, ext_r, rel_r, rep_r, kd_r, cext_r, err_r;
   logic [7:0] code_r, asc_r, cc_r, pc_r;

   int total = 0;
   int bad   = 0;

   logic [7:0] fifo[$];
   int  cyc = 0;
   int  n_evt_s = 0;
   int  n_evt_r = 0;
   int  n_pop = 0;
   int  pop_cyc[$];
   bit  rep_hist_r[$];

   always #5 clk = ~clk;

   ps2_key_decoder #(.CNT_W(8), .SUPPRESS_REPEAT(1'b1)) dut_s (
      .clk(clk), .rst(rst), .ps2_data(ps2_data), .ps2_ready(ps2_ready),
      .ps2_overflow(ps2_overflow), .ps2_nextdata_n(nd_s),
      .evt_valid(ev_s), .evt_code(code_s), .evt_ext(ext_s),
      .evt_release(rel_s), .evt_repeat(rep_s), .evt_ascii(asc_s),
      .key_down(kd_s), .cur_code(cc_s), .cur_ext(cext_s),
      .press_cnt(pc_s), .err(err_s)
   );

   ps2_key_decoder #(.CNT_W(8), .SUPPRESS_REPEAT(1'b0)) dut_r (
      .clk(clk), .rst(rst), .ps2_data(ps2_data), .ps2_ready(ps2_ready),
      .ps2_overflow(ps2_overflow), .ps2_nextdata_n(nd_r),
      .evt_valid(ev_r), .evt_code(code_r), .evt_ext(ext_r),
      .evt_release(rel_r), .evt_repeat(rep_r), .evt_ascii(asc_r),
      .key_down(kd_r), .cur_code(cc_r), .cur_ext(cext_r),
      .press_cnt(pc_r), .err(err_r)
   );

   // FIFO model and event monitor, evaluated mid-cycle away from the edge.
   always @(negedge clk) begin
      cyc++;
      if (ev_s) n_evt_s++;
      if (ev_r) begin
         rep_hist_r.push_back(rep_r);
         n_evt_r++;
      end
      if (!nd_s) begin
         n_pop++;
         pop_cyc.push_back(cyc);
         if (fifo.size() != 0) void'(fifo.pop_front());
      end
      ps2_ready = (fifo.size() != 0);
      ps2_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic clear_counts();
      n_evt_s = 0;
      n_evt_r = 0;
      n_pop   = 0;
      pop_cyc.delete();
      rep_hist_r.delete();
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      clear_counts();
   endtask

   // Queue bytes and wait (bounded) until they are consumed and decoded.
   task automatic send(input logic [7:0] b[$]);
      int i;
      @(posedge clk); #1;
      foreach (b[k]) fifo.push_back(b[k]);
      for (i = 0; i < 200 && fifo.size() != 0; i++) @(posedge clk);
      chk("drain_timeout", {31'd0, fifo.size() == 0}, 32'd1);
      repeat (4) @(posedge clk);
      #1;
   endtask

   initial begin
      // ---- reset state ----
      repeat (3) @(posedge clk);
      #1;
      chk("rst_nextdata_n", nd_s, 1);
      chk("rst_evt_valid", ev_s, 0);
      chk("rst_key_down", kd_s, 0);
      chk("rst_press_cnt", pc_s, 0);
      chk("rst_err", err_s, 0);
      chk("rst_evt_code", code_s, 0);
      rst = 1'b0;
      clear_counts();

      // ---- single make 0x15: latency and strobe width ----
      @(posedge clk); #1;
      fifo.push_back(8'h15);
      @(negedge clk); #1;           // ready now visible, sampled at next edge
      @(posedge clk); #1;           // POP cycle
      chk("pop_nd_low", nd_s, 0);
      chk("pop_nd_low_r", nd_r, 0);
      chk("pop_no_evt", ev_s, 0);
      @(posedge clk); #1;           // GAP cycle: event visible
      chk("gap_evt_valid", ev_s, 1);
      chk("gap_nd_high", nd_s, 1);
      chk("mk_code", code_s, 8'h15);
      chk("mk_ascii", asc_s, 8'h71);
      chk("mk_release", rel_s, 0);
      chk("mk_press_cnt", pc_s, 1);
      chk("mk_key_down", kd_s, 1);
      chk("mk_cur_code", cc_s, 8'h15);
      @(posedge clk); #1;
      chk("evt_pulse_end", ev_s, 0);
      chk("evt_code_hold", code_s, 8'h15);
      repeat (3) @(posedge clk); #1;
      chk("single_pop", n_pop, 1);
      chk("single_evt", n_evt_s, 1);

      // ---- typematic repeats then break ----
      do_reset();
      send('{8'h15, 8'h15, 8'h15, 8'hF0, 8'h15});
      chk("sup_events", n_evt_s, 2);
      chk("sup_press_cnt", pc_s, 1);
      chk("sup_key_down", kd_s, 0);
      chk("sup_release", rel_s, 1);
      chk("sup_ascii", asc_s, 8'h71);
      chk("rep_events", n_evt_r, 4);
      chk("rep_press_cnt", pc_r, 1);
      chk("rep_key_down", kd_r, 0);
      if (rep_hist_r.size() == 4) begin
         chk("rep_flag_1", rep_hist_r[0], 0);
         chk("rep_flag_2", rep_hist_r[1], 1);
         chk("rep_flag_3", rep_hist_r[2], 1);
         chk("rep_flag_4", rep_hist_r[3], 0);
      end else begin
         chk("rep_hist_size", rep_hist_r.size(), 4);
      end
      chk("pops_5", n_pop, 5);

      // ---- extended make/break, back-to-back bytes ----
      do_reset();
      send('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75});
      chk("ext_events", n_evt_s, 2);
      chk("ext_flag", ext_s, 1);
      chk("ext_code", code_s, 8'h75);
      chk("ext_ascii", asc_s, 8'h00);
      chk("ext_release", rel_s, 1);
      chk("ext_key_down", kd_s, 0);
      chk("ext_press_cnt", pc_s, 1);
      if (pop_cyc.size() == 5) begin
         for (int k = 1; k < 5; k++)
            chk("byte_spacing", pop_cyc[k] - pop_cyc[k-1], 3);
      end else begin
         chk("ext_pop_count", pop_cyc.size(), 5);
      end

      // ---- release of a non-held key ----
      do_reset();
      send('{8'h23, 8'h1C, 8'hF0, 8'h23});
      chk("two_cur_code", cc_s, 8'h1C);
      chk("two_key_down", kd_s, 1);
      chk("two_press_cnt", pc_s, 2);
      chk("two_release", rel_s, 1);
      chk("two_code", code_s, 8'h23);
      chk("two_ascii", asc_s, 8'h64);
      chk("two_events", n_evt_s, 3);

      // ---- overflow stickiness and reset after a lone F0 ----
      do_reset();
      @(posedge clk); #1;
      ps2_overflow = 1'b1;
      @(posedge clk); #1;
      ps2_overflow = 1'b0;
      chk("err_set", err_s, 1);
      repeat (5) @(posedge clk); #1;
      chk("err_sticky", err_s, 1);
      send('{8'hF0});
      chk("f0_no_evt", n_evt_s, 0);
      do_reset();
      chk("err_cleared", err_s, 0);
      send('{8'h15});
      chk("post_rst_events", n_evt_s, 1);
      chk("post_rst_release", rel_s, 0);
      chk("post_rst_press", pc_s, 1);
      chk("post_rst_err", err_s, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
